// File: rtl/crc4_encoder.sv
// Transmit-side CRC-4 (x^4+x+1) generator: bit-serial LFSR appends crc[3:0] below the payload.
// Optional macro CRC_SELFCHECK_EN adds a CHECK state that re-divides the codeword before Ready.
module crc4_encoder #(
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_BITS-1:0]   InputData,
  output logic                   Ready,
  output logic [DATA_BITS+3:0]   OutputData,
  output logic                   check_ok
);

  localparam int unsigned CODE_BITS = DATA_BITS + 4;
  localparam int unsigned CNT_W     = $clog2(CODE_BITS + 1);
  localparam logic [3:0]  POLY_LOW  = 4'b0011;

`ifdef CRC_SELFCHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
`endif

  state_e                  state_q;
  logic [DATA_BITS-1:0]    sr_q;
  logic [DATA_BITS-1:0]    data_q;
  logic [3:0]              crc_q;
  logic [3:0]              crc_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    in_bit;
  logic                    ready_q;
  logic                    check_ok_q;
  logic [CODE_BITS-1:0]    out_q;
`ifdef CRC_SELFCHECK_EN
  logic [CODE_BITS-1:0]    chk_sr_q;
`endif

  // One LFSR step shared by the payload shift and the codeword re-division.
  always_comb begin
    in_bit = sr_q[DATA_BITS-1];
`ifdef CRC_SELFCHECK_EN
    if (state_q == CHECK) in_bit = chk_sr_q[CODE_BITS-1];
`endif
    crc_d = {crc_q[2:0], 1'b0} ^ ((crc_q[3] ^ in_bit) ? POLY_LOW : 4'b0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      data_q     <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      check_ok_q <= 1'b0;
      out_q      <= '0;
`ifdef CRC_SELFCHECK_EN
      chk_sr_q   <= '0;
`endif
    end else if (!start) begin
      // Abort/clear: OutputData deliberately keeps its last codeword.
      state_q    <= IDLE;
      crc_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      check_ok_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sr_q    <= InputData;
          data_q  <= InputData;
          crc_q   <= '0;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          crc_q <= crc_d;
          sr_q  <= sr_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            out_q <= {data_q, crc_d};
`ifdef CRC_SELFCHECK_EN
            chk_sr_q <= {data_q, crc_d};
            crc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= CHECK;
`else
            ready_q    <= 1'b1;
            check_ok_q <= 1'b1;
            state_q    <= DONE;
`endif
          end
        end
`ifdef CRC_SELFCHECK_EN
        CHECK: begin
          crc_q    <= crc_d;
          chk_sr_q <= chk_sr_q << 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CODE_BITS - 1)) begin
            ready_q    <= 1'b1;
            check_ok_q <= (crc_d == 4'b0000);
            state_q    <= DONE;
          end
        end
`endif
        DONE: begin
          // Hold until start drops; no recapture while start stays high.
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ready      = ready_q;
  assign OutputData = out_q;
  assign check_ok   = check_ok_q;

endmodule

// File: tb/tb_crc4_encoder.sv
// Directed bench for crc4_encoder: known codewords, latency, abort, async reset, loopback.
module tb_crc4_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] InputData;
  logic        Ready;
  logic [19:0] OutputData;
  logic        check_ok;

  int total;
  int bad;

`ifdef CRC_SELFCHECK_EN
  localparam int LAT = 37;
`else
  localparam int LAT = 17;
`endif

  crc4_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .InputData  (InputData),
    .Ready      (Ready),
    .OutputData (OutputData),
    .check_ok   (check_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receive-side reference: polynomial long division by 10011.
  function automatic logic [3:0] rem20(input logic [19:0] v);
    logic [19:0] t;
    logic [19:0] g;
    t = v;
    for (int i = 19; i >= 4; i--) begin
      if (t[i]) begin
        g = 20'(5'b10011) << (i - 4);
        t = t ^ g;
      end
    end
    return t[3:0];
  endfunction

  task automatic do_frame(input logic [15:0] d, input logic [19:0] exp, input string nm);
    InputData = d;
    start = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    total++;
    if (Ready !== 1'b0) begin
      bad++; $display("FAIL %s early_ready: got=%b want=0", nm, Ready);
    end
    @(posedge clk); #1;
    total++;
    if (Ready !== 1'b1) begin
      bad++; $display("FAIL %s ready: got=%b want=1", nm, Ready);
    end
    total++;
    if (OutputData !== exp) begin
      bad++; $display("FAIL %s codeword: got=%h want=%h", nm, OutputData, exp);
    end
    total++;
    if (check_ok !== 1'b1) begin
      bad++; $display("FAIL %s check_ok: got=%b want=1", nm, check_ok);
    end
    InputData = ~d;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (Ready !== 1'b1 || OutputData !== exp) begin
      bad++; $display("FAIL %s hold: ready=%b data=%h want ready=1 data=%h", nm, Ready, OutputData, exp);
    end
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (Ready !== 1'b0 || check_ok !== 1'b0 || OutputData !== exp) begin
      bad++; $display("FAIL %s clear: ready=%b ok=%b data=%h want 0 0 %h", nm, Ready, check_ok, OutputData, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; InputData = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (Ready !== 1'b0 || OutputData !== 20'h00000 || check_ok !== 1'b0) begin
      bad++; $display("FAIL reset_state: ready=%b data=%h ok=%b want 0 00000 0", Ready, OutputData, check_ok);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    do_frame(16'h0001, 20'h00013, "v0001");
    do_frame(16'h8000, 20'h80003, "v8000");
    do_frame(16'hFFFF, 20'hFFFF3, "vFFFF");
    do_frame(16'h0002, 20'h00026, "v0002");
    do_frame(16'h0003, 20'h00035, "v0003");
    do_frame(16'h0010, 20'h00105, "v0010");
    do_frame(16'h0000, 20'h00000, "v0000");
  endtask

  task automatic test_abort();
    do_frame(16'h0002, 20'h00026, "pre_abort");
    InputData = 16'h8000;
    start = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (Ready !== 1'b0 || OutputData !== 20'h00026) begin
      bad++; $display("FAIL abort_idle: ready=%b data=%h want 0 00026", Ready, OutputData);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (Ready !== 1'b0) begin
      bad++; $display("FAIL abort_stay: ready=%b want 0", Ready);
    end
    do_frame(16'h0001, 20'h00013, "rearm");
  endtask

  task automatic test_async_reset();
    do_frame(16'hFFFF, 20'hFFFF3, "pre_rst");
    InputData = 16'h1234;
    start = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (Ready !== 1'b0 || OutputData !== 20'h00000 || check_ok !== 1'b0) begin
      bad++; $display("FAIL async_reset: ready=%b data=%h ok=%b want 0 00000 0", Ready, OutputData, check_ok);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    logic [15:0] d;
    logic [19:0] cw;
    logic [19:0] exp;
    int j;
    for (int k = 0; k < 4; k++) begin
      d   = 16'($urandom_range(0, 65535));
      exp = {d, rem20({d, 4'b0000})};
      do_frame(d, exp, "loop");
      cw = OutputData;
      total++;
      if (rem20(cw) !== 4'b0000) begin
        bad++; $display("FAIL loop_valid: rem=%h want 0 cw=%h", rem20(cw), cw);
      end
      j = int'($urandom_range(0, 19));
      cw[j] = ~cw[j];
      total++;
      if (rem20(cw) === 4'b0000) begin
        bad++; $display("FAIL loop_flip: bit=%0d rem=0 want nonzero", j);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_vectors();
    test_abort();
    test_async_reset();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
